request_scheduler: RTL and testbench

Parametrised elevator request scheduler. It latches hall calls (up/down) and car calls per floor, and clears them when the car is served at a floor. It reports whether pending requests lie above, below or at the current floor, and runs a registered direction state machine (IDLE/UP/DOWN) with collective-selective stop decisions. It sits between the button/keypad front end and the car motion controller, which supplies `floor`, `moving` and `served`.

---
 rtl/request_scheduler.sv | 142 ++++++++++++++
 tb/tb_request_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/request_scheduler.sv
// request_scheduler: latches elevator hall/car calls per floor, derives above/below/here
// aggregates and runs a collective-selective direction FSM with stop decisions.
//
// state | meaning
// IDLE  | no travel direction committed; any hall call at this floor stops the car
// UP    | sweeping upward; stops for up calls, car calls, or a down call at the top of the sweep
// DOWN  | sweeping downward; stops for down calls, car calls, or an up call at the bottom of the sweep
module request_scheduler #(
   parameter int FLOORS  = 8,
   parameter int FLOOR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FLOORS-1:0]  upCall,
   input  logic [FLOORS-1:0]  downCall,
   input  logic [FLOORS-1:0]  carCall,
   input  logic [FLOOR_W-1:0] floor,
   input  logic               moving,
   input  logic               served,
   output logic [FLOORS-1:0]  pendingUp,
   output logic [FLOORS-1:0]  pendingDown,
   output logic [FLOORS-1:0]  pendingCar,
   output logic               requestAbove,
   output logic               requestBelow,
   output logic               requestHere,
   output logic [1:0]         dir,
   output logic               stopHere
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } dirState_e;

   // No up call exists at the top floor and no down call at the bottom floor.
   localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

   dirState_e         state;
   dirState_e         nextState;
   logic              floorValid;
   logic [FLOORS-1:0] pendAll;
   logic [FLOORS-1:0] clearUp;
   logic [FLOORS-1:0] clearDown;
   logic [FLOORS-1:0] clearCar;
   logic              hereUp;
   logic              hereDown;
   logic              hereCar;

   assign floorValid = (32'(floor) < 32'(FLOORS));
   assign pendAll    = pendingUp | pendingDown | pendingCar;

   // An out-of-range floor reports everything as below and nothing here.
   always_comb begin
      requestAbove = 1'b0;
      requestBelow = 1'b0;
      hereUp       = 1'b0;
      hereDown     = 1'b0;
      hereCar      = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (!floorValid) begin
            requestBelow = requestBelow | pendAll[i];
         end else if (FLOOR_W'(i) > floor) begin
            requestAbove = requestAbove | pendAll[i];
         end else if (FLOOR_W'(i) < floor) begin
            requestBelow = requestBelow | pendAll[i];
         end else begin
            hereUp   = pendingUp[i];
            hereDown = pendingDown[i];
            hereCar  = pendingCar[i];
         end
      end
   end

   assign requestHere = hereUp | hereDown | hereCar;

   always_comb begin
      clearUp   = '0;
      clearDown = '0;
      clearCar  = '0;
      if (served && floorValid) begin
         for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) == floor) begin
               clearCar[i]  = 1'b1;
               clearUp[i]   = (state != DOWN) || !requestBelow;
               clearDown[i] = (state != UP) || !requestAbove;
            end
         end
      end
   end

   // A new press in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         pendingUp   <= '0;
         pendingDown <= '0;
         pendingCar  <= '0;
      end else begin
         pendingUp   <= (pendingUp & ~clearUp) | (upCall & UP_MASK);
         pendingDown <= (pendingDown & ~clearDown) | (downCall & DOWN_MASK);
         pendingCar  <= (pendingCar & ~clearCar) | carCall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      if (!moving) begin
         case (state)
            IDLE, UP: begin
               if (requestAbove)      nextState = UP;
               else if (requestBelow) nextState = DOWN;
               else                   nextState = IDLE;
            end
            DOWN: begin
               if (requestBelow)      nextState = DOWN;
               else if (requestAbove) nextState = UP;
               else                   nextState = IDLE;
            end
            default: nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      stopHere = hereCar
               | ((state == UP)   && (hereUp   || (!requestAbove && hereDown)))
               | ((state == DOWN) && (hereDown || (!requestBelow && hereUp)))
               | ((state == IDLE) && (hereUp || hereDown));
   end

   assign dir = state;

endmodule

// File: tb/tb_request_scheduler.sv
// Bench for request_scheduler: three instances (8, 16 and 6 floors) checked every cycle
// against a bit-vector model, plus directed scenarios with literal expectations.
module tb_request_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] upC;
   logic [31:0] dnC;
   logic [31:0] carC;
   logic [4:0]  fl [3];
   logic        mv [3];
   logic        sv [3];

   logic [31:0] aUp [3];
   logic [31:0] aDn [3];
   logic [31:0] aCar [3];
   logic [3:0]  aFlags [3];
   logic [1:0]  aDir [3];

   int checks   = 0;
   int failures = 0;
   bit run      = 1'b0;

   bit [31:0] mU [3];
   bit [31:0] mD [3];
   bit [31:0] mC [3];
   int        mDir [3];

   localparam int NF [3] = '{8, 16, 6};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gInst
      localparam int NFG = (g == 0) ? 8 : (g == 1) ? 16 : 6;
      localparam int FW  = (g == 1) ? 4 : 3;
      logic [NFG-1:0] pu;
      logic [NFG-1:0] pd;
      logic [NFG-1:0] pc;
      logic           ab;
      logic           be;
      logic           he;
      logic           st;
      logic [1:0]     dr;

      request_scheduler #(.FLOORS(NFG), .FLOOR_W(FW)) dut (
         .clk(clk),
         .rst(rst),
         .upCall(upC[NFG-1:0]),
         .downCall(dnC[NFG-1:0]),
         .carCall(carC[NFG-1:0]),
         .floor(fl[g][FW-1:0]),
         .moving(mv[g]),
         .served(sv[g]),
         .pendingUp(pu),
         .pendingDown(pd),
         .pendingCar(pc),
         .requestAbove(ab),
         .requestBelow(be),
         .requestHere(he),
         .dir(dr),
         .stopHere(st)
      );

      assign aUp[g]    = 32'(pu);
      assign aDn[g]    = 32'(pd);
      assign aCar[g]   = 32'(pc);
      assign aFlags[g] = {ab, be, he, st};
      assign aDir[g]   = dr;
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d actual=%0h expected=%0h", nm, k, act, exp);
      end
   endtask

   // Model: outputs follow from the pending sets and the floor; state advances on each edge.
   always @(negedge clk) begin : cmp
      bit [31:0] p, full, nu, nd, nc;
      int        f, d, nf;
      bit        valid, above, below, here, stop;
      if (run) begin
         for (int k = 0; k < 3; k++) begin
            nf    = NF[k];
            full  = (32'd1 << nf) - 32'd1;
            f     = int'(fl[k]);
            d     = mDir[k];
            valid = f < nf;
            p     = mU[k] | mD[k] | mC[k];
            above = valid && ((p >> (f + 1)) != 0);
            below = valid ? ((p & ((32'd1 << f) - 32'd1)) != 0) : (p != 0);
            here  = valid && p[f];
            stop  = valid && (mC[k][f]
                    || (d == 1 && mU[k][f]) || (d == 2 && mD[k][f])
                    || (d == 0 && (mU[k][f] || mD[k][f]))
                    || (d == 1 && !above && mD[k][f])
                    || (d == 2 && !below && mU[k][f]));
            chk("pendingUp", k, aUp[k], mU[k]);
            chk("pendingDown", k, aDn[k], mD[k]);
            chk("pendingCar", k, aCar[k], mC[k]);
            chk("aboveBelowHereStop", k, 32'(aFlags[k]), 32'({above, below, here, stop}));
            chk("dir", k, 32'(aDir[k]), 32'(d));

            if (rst) begin
               mU[k] = '0; mD[k] = '0; mC[k] = '0; mDir[k] = 0;
            end else begin
               nu = mU[k]; nd = mD[k]; nc = mC[k];
               if (valid && sv[k]) begin
                  nc[f] = 1'b0;
                  if (d != 2 || !below) nu[f] = 1'b0;
                  if (d != 1 || !above) nd[f] = 1'b0;
               end
               mU[k] = nu | (upC & full & ~(32'd1 << (nf - 1)));
               mD[k] = nd | (dnC & full & ~32'd1);
               mC[k] = nc | (carC & full);
               if (!mv[k]) begin
                  if (d == 2) mDir[k] = below ? 2 : above ? 1 : 0;
                  else        mDir[k] = above ? 1 : below ? 2 : 0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; upC = 32'hFF; dnC = '0; carC = '0;
      for (int k = 0; k < 3; k++) begin
         fl[k] = '0; mv[k] = 1'b0; sv[k] = 1'b0;
         mU[k] = '0; mD[k] = '0; mC[k] = '0; mDir[k] = 0;
      end
      step();
      run = 1'b1;
      chk("rst_pendUp", 0, aUp[0], 32'h0);
      chk("rst_flags", 0, 32'(aFlags[0]), 32'h0);
      chk("rst_dir", 0, 32'(aDir[0]), 32'h0);
      rst = 1'b0;
      step();
      chk("top_up_masked", 0, aUp[0], 32'h7F);
      upC = '0; rst = 1'b1;
      step();
      rst = 1'b0;

      // upward sweep
      fl[0] = 5'd2; carC = 32'h20;
      step();
      carC = '0;
      chk("sweep_pendCar", 0, aCar[0], 32'h20);
      chk("sweep_above", 0, 32'(aFlags[0][3]), 32'h1);
      chk("sweep_dir_lag", 0, 32'(aDir[0]), 32'h0);
      step();
      chk("sweep_dir_up", 0, 32'(aDir[0]), 32'h1);
      fl[0] = 5'd5; #1;
      chk("sweep_stop", 0, 32'(aFlags[0][0]), 32'h1);
      sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      chk("sweep_cleared", 0, aCar[0], 32'h0);
      step();
      chk("sweep_dir_idle", 0, 32'(aDir[0]), 32'h0);

      // direction-selective stop
      fl[0] = 5'd3; dnC = 32'h08; carC = 32'h40;
      step();
      dnC = '0; carC = '0;
      step();
      chk("sel_dir_up", 0, 32'(aDir[0]), 32'h1);
      chk("sel_no_stop", 0, 32'(aFlags[0][0]), 32'h0);
      fl[0] = 5'd6; sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      chk("sel_dir_down", 0, 32'(aDir[0]), 32'h2);
      fl[0] = 5'd3; #1;
      chk("sel_stop_down", 0, 32'(aFlags[0][0]), 32'h1);
      sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      chk("sel_cleared", 0, aDn[0], 32'h0);
      step();
      chk("sel_idle", 0, 32'(aDir[0]), 32'h0);

      // turnaround at the top floor
      dnC = 32'h80;
      step();
      dnC = '0;
      step();
      chk("turn_dir_up", 0, 32'(aDir[0]), 32'h1);
      fl[0] = 5'd7; #1;
      chk("turn_stop", 0, 32'(aFlags[0][0]), 32'h1);
      sv[0] = 1'b1;
      step();
      sv[0] = 1'b0;
      chk("turn_cleared", 0, aDn[0], 32'h0);
      chk("turn_idle", 0, 32'(aDir[0]), 32'h0);

      // simultaneous set/clear, then frozen direction while moving
      fl[0] = 5'd4; sv[0] = 1'b1; carC = 32'h10;
      step();
      sv[0] = 1'b0; carC = '0;
      chk("setwins", 0, aCar[0], 32'h10);
      mv[0] = 1'b1; upC = 32'h02;
      step();
      upC = '0;
      step();
      step();
      chk("frozen_dir", 0, 32'(aDir[0]), 32'h0);
      chk("frozen_below", 0, 32'(aFlags[0][2]), 32'h1);
      mv[0] = 1'b0;
      step();
      chk("released_dir", 0, 32'(aDir[0]), 32'h2);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // 16-floor masking and out-of-range floor on the 6-floor instance
      fl[1] = 5'd15; fl[2] = 5'd7; upC = 32'h8000; dnC = 32'h1; carC = 32'h1;
      step();
      upC = '0; dnC = '0; carC = '0;
      chk("p16_up15", 1, aUp[1], 32'h0);
      chk("p16_down0", 1, aDn[1], 32'h0);
      chk("p16_car0", 1, aCar[1], 32'h1);
      chk("p16_below", 1, 32'(aFlags[1][2]), 32'h1);
      chk("oor_flags", 2, 32'(aFlags[2]), 32'h4);
      sv[2] = 1'b1;
      step();
      sv[2] = 1'b0;
      chk("oor_served_ignored", 2, aCar[2], 32'h1);

      // randomized traffic with quiet stretches so requests drain
      for (int c = 0; c < 4000; c++) begin
         if (((c / 250) % 3) == 2) begin
            upC = '0; dnC = '0; carC = '0;
         end else begin
            upC  = $urandom & $urandom & $urandom;
            dnC  = $urandom & $urandom & $urandom;
            carC = $urandom & $urandom & $urandom;
         end
         for (int k = 0; k < 3; k++) begin
            fl[k] = 5'($urandom_range(0, (k == 2) ? 7 : NF[k] - 1));
            mv[k] = ($urandom_range(0, 3) == 0);
            sv[k] = ($urandom_range(0, 2) == 0);
         end
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
